// File: rtl/video_pkg.sv
// Shared video definitions: 1080p active-area constants and the block-move FSM encoding.
package video_pkg;

  localparam int H_ACT_1080P = 1920;
  localparam int V_ACT_1080P = 1080;
  localparam int H_TOT_1080P = 2200;
  localparam int V_TOT_1080P = 1125;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_STEP_X,
    S_STEP_Y,
    S_COMMIT
  } move_state_e;

endpackage

// File: rtl/bounce_axis.sv
// One axis of block motion: step pos by STEP in direction dir (0 = +, 1 = -), clamping at 0 / LIMIT.
module bounce_axis #(
  parameter int BITS  = 12,
  parameter int LIMIT = 1820,
  parameter int STEP  = 4
) (
  input  logic [BITS-1:0] pos,
  input  logic            dir,
  output logic [BITS-1:0] next_pos,
  output logic            next_dir,
  output logic            hit
);

  localparam logic [BITS:0]   LIM_W  = (BITS+1)'(LIMIT);
  localparam logic [BITS:0]   STEP_W = (BITS+1)'(STEP);
  localparam logic [BITS-1:0] STEP_N = BITS'(STEP);

  logic [BITS:0] pos_w;
  logic [BITS:0] sum;

  // One extra bit so pos+STEP near the top of the range cannot wrap.
  always_comb begin
    pos_w    = {1'b0, pos};
    sum      = pos_w + STEP_W;
    next_pos = pos;
    next_dir = dir;
    hit      = 1'b0;
    if (!dir) begin
      if (sum >= LIM_W) begin
        next_pos = LIM_W[BITS-1:0];
        next_dir = 1'b1;
        hit      = 1'b1;
      end else begin
        next_pos = sum[BITS-1:0];
      end
    end else begin
      if (pos_w <= STEP_W) begin
        next_pos = '0;
        next_dir = 1'b0;
        hit      = 1'b1;
      end else begin
        next_pos = pos - STEP_N;
      end
    end
  end

endmodule

// File: rtl/block_move_ctrl.sv
// Per-frame block motion sequencer plus per-pixel inside-block flag for the HDMI demo pixel mux.
module block_move_ctrl
  import video_pkg::*;
#(
  parameter int X_BITS    = 12,
  parameter int Y_BITS    = 12,
  parameter int H_ACT     = H_ACT_1080P,
  parameter int V_ACT     = V_ACT_1080P,
  parameter int BLOCK_W   = 100,
  parameter int BLOCK_H   = 100,
  parameter int STEP_X    = 4,
  parameter int STEP_Y    = 2,
  parameter int FRAME_DIV = 1
) (
  input  logic              pix_clk,
  input  logic              rst,
  input  logic              vs_in,
  input  logic [X_BITS-1:0] act_x,
  input  logic [Y_BITS-1:0] act_y,
  input  logic              pause,
  output logic [X_BITS-1:0] block_x,
  output logic [Y_BITS-1:0] block_y,
  output logic [2:0]        color_idx,
  output logic              in_block,
  output logic              update_busy
);

  localparam int                FC_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FC_W-1:0]   FC_LAST = FC_W'(FRAME_DIV - 1);
  localparam logic [X_BITS:0]   BW      = (X_BITS+1)'(BLOCK_W);
  localparam logic [Y_BITS:0]   BH      = (Y_BITS+1)'(BLOCK_H);

  move_state_e       state;
  logic              vs_d;
  logic [FC_W-1:0]   frame_cnt;
  logic              dir_x, dir_y;
  logic [X_BITS-1:0] pend_x;
  logic [Y_BITS-1:0] pend_y;
  logic              pend_dx, pend_dy, hit_x, hit_y;
  logic [X_BITS-1:0] nx;
  logic [Y_BITS-1:0] ny;
  logic              ndx, ndy, hx, hy;
  logic              frame_ev, in_win;

  bounce_axis #(.BITS(X_BITS), .LIMIT(H_ACT - BLOCK_W), .STEP(STEP_X)) u_axis_x (
    .pos(block_x), .dir(dir_x), .next_pos(nx), .next_dir(ndx), .hit(hx)
  );

  bounce_axis #(.BITS(Y_BITS), .LIMIT(V_ACT - BLOCK_H), .STEP(STEP_Y)) u_axis_y (
    .pos(block_y), .dir(dir_y), .next_pos(ny), .next_dir(ndy), .hit(hy)
  );

  assign frame_ev    = vs_in & ~vs_d;
  assign update_busy = (state != S_IDLE);

  always_comb begin
    in_win = (act_x >= block_x) && ({1'b0, act_x} < ({1'b0, block_x} + BW)) &&
             (act_y >= block_y) && ({1'b0, act_y} < ({1'b0, block_y} + BH));
  end

  // Step results are held in pend_* and only become visible in S_COMMIT, so a reset mid-update leaves nothing half-applied.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      state     <= S_IDLE;
      vs_d      <= 1'b0;
      frame_cnt <= '0;
      block_x   <= '0;
      block_y   <= '0;
      dir_x     <= 1'b0;
      dir_y     <= 1'b0;
      pend_x    <= '0;
      pend_y    <= '0;
      pend_dx   <= 1'b0;
      pend_dy   <= 1'b0;
      hit_x     <= 1'b0;
      hit_y     <= 1'b0;
      color_idx <= 3'd0;
      in_block  <= 1'b0;
    end else begin
      vs_d     <= vs_in;
      in_block <= in_win;
      case (state)
        S_IDLE: if (frame_ev) state <= S_COUNT;
        S_COUNT: begin
          if (pause) begin
            state <= S_IDLE;
          end else if (frame_cnt == FC_LAST) begin
            frame_cnt <= '0;
            state     <= S_STEP_X;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
            state     <= S_IDLE;
          end
        end
        S_STEP_X: begin
          pend_x  <= nx;
          pend_dx <= ndx;
          hit_x   <= hx;
          state   <= S_STEP_Y;
        end
        S_STEP_Y: begin
          pend_y  <= ny;
          pend_dy <= ndy;
          hit_y   <= hy;
          state   <= S_COMMIT;
        end
        S_COMMIT: begin
          block_x <= pend_x;
          block_y <= pend_y;
          dir_x   <= pend_dx;
          dir_y   <= pend_dy;
          if (hit_x | hit_y) color_idx <= color_idx + 3'd1;
          hit_x   <= 1'b0;
          hit_y   <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_move_ctrl.sv
// Scoreboard bench for block_move_ctrl: expected post-update positions are queued per vsync edge and checked when update_busy drops.
module tb_block_move_ctrl;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [2:0]  c;
  } pos_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs1 = 1'b0, vs3 = 1'b0, pause1 = 1'b0, pause3 = 1'b0;
  logic [11:0] ax = '0, ay = '0;
  logic [11:0] bx1, by1, bx3, by3;
  logic [2:0]  c1, c3;
  logic        inb1, inb3, busy1, busy3;

  pos_t q1[$];
  pos_t q3[$];
  logic inb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  block_move_ctrl #(.X_BITS(12), .Y_BITS(12), .H_ACT(64), .V_ACT(32), .BLOCK_W(8), .BLOCK_H(4),
                    .STEP_X(4), .STEP_Y(2), .FRAME_DIV(1)) dut (
    .pix_clk(clk), .rst(rst), .vs_in(vs1), .act_x(ax), .act_y(ay), .pause(pause1),
    .block_x(bx1), .block_y(by1), .color_idx(c1), .in_block(inb1), .update_busy(busy1)
  );

  block_move_ctrl #(.X_BITS(12), .Y_BITS(12), .H_ACT(64), .V_ACT(32), .BLOCK_W(8), .BLOCK_H(4),
                    .STEP_X(4), .STEP_Y(2), .FRAME_DIV(3)) dut3 (
    .pix_clk(clk), .rst(rst), .vs_in(vs3), .act_x(ax), .act_y(ay), .pause(pause3),
    .block_x(bx3), .block_y(by3), .color_idx(c3), .in_block(inb3), .update_busy(busy3)
  );

  task automatic chk(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  // Monitors: every fall of update_busy consumes one expected entry.
  logic busy1_d = 1'b0, busy3_d = 1'b0;
  pos_t p1, p3;

  always @(negedge clk) begin
    if (busy1_d && !busy1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL upd1_spurious: got update at x=%0d y=%0d want none", bx1, by1);
      end else begin
        p1 = q1.pop_front();
        chk("upd1_x", int'(bx1), int'(p1.x));
        chk("upd1_y", int'(by1), int'(p1.y));
        chk("upd1_color", int'(c1), int'(p1.c));
      end
    end
    busy1_d = busy1;
  end

  always @(negedge clk) begin
    if (busy3_d && !busy3) begin
      if (q3.size() == 0) begin
        total++; bad++;
        $display("FAIL upd3_spurious: got update at x=%0d y=%0d want none", bx3, by3);
      end else begin
        p3 = q3.pop_front();
        chk("upd3_x", int'(bx3), int'(p3.x));
        chk("upd3_y", int'(by3), int'(p3.y));
        chk("upd3_color", int'(c3), int'(p3.c));
      end
    end
    busy3_d = busy3;
  end

  // in_block has one cycle of latency: stage the expectation at the capturing edge.
  logic inb_v = 1'b0, inb_e = 1'b0;
  always @(posedge clk) begin
    if (inb_q.size() != 0) begin
      inb_e = inb_q.pop_front();
      inb_v = 1'b1;
    end else begin
      inb_v = 1'b0;
    end
  end
  always @(negedge clk) if (inb_v) chk("in_block", int'(inb1), int'(inb_e));

  task automatic vs_edge1(input pos_t e);
    @(posedge clk); #1 vs1 = 1'b1; q1.push_back(e);
    @(posedge clk); #1 vs1 = 1'b0;
    repeat (7) @(posedge clk);
  endtask

  task automatic vs_edge3(input pos_t e, input logic pz);
    @(posedge clk); #1 vs3 = 1'b1; pause3 = pz; q3.push_back(e);
    @(posedge clk); #1 vs3 = 1'b0;
    repeat (7) @(posedge clk);
    pause3 = 1'b0;
  endtask

  int ex3[14] = '{0, 0, 4, 4, 4, 8, 8, 8, 8, 8, 8, 8, 8, 12};
  int ey3[14] = '{0, 0, 2, 2, 2, 4, 4, 4, 4, 4, 4, 4, 4, 6};
  int pz3[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_x", int'(bx1), 0);
    chk("rst_y", int'(by1), 0);
    chk("rst_color", int'(c1), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_inb", int'(inb1), 0);
    chk("rst3_x", int'(bx3), 0);
    chk("rst3_busy", int'(busy3), 0);

    // First move: busy for exactly 4 cycles, lands at (4,2).
    @(posedge clk); #1 vs1 = 1'b1; q1.push_back('{12'd4, 12'd2, 3'd0});
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy1) cnt++;
    end
    chk("busy_len", cnt, 4);
    vs1 = 1'b0;
    repeat (3) @(posedge clk);

    // Moves 2..14 toward the corner (56,28): both axes hit together, colour +1 only.
    for (int k = 2; k <= 14; k++)
      vs_edge1('{12'(4 * k), 12'(2 * k), (k == 14) ? 3'd1 : 3'd0});
    // Back toward the origin; move 14 of the return hits (0,0) as a corner.
    for (int m = 1; m <= 14; m++)
      vs_edge1('{12'(56 - 4 * m), 12'(28 - 2 * m), (m == 14) ? 3'd2 : 3'd1});
    vs_edge1('{12'd4, 12'd2, 3'd2});

    // Block at (4,2): sweep a 16x8 window.
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) begin
        @(posedge clk); #1 ax = 12'(x); ay = 12'(y);
        inb_q.push_back((x >= 4) && (x <= 11) && (y >= 2) && (y <= 5));
      end
    repeat (3) @(posedge clk);
    ax = '0; ay = '0;

    // Reset while in S_STEP_Y: nothing commits.
    @(posedge clk); #1 vs1 = 1'b1; q1.push_back('{12'd0, 12'd0, 3'd0});
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; vs1 = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy1), 0);
    chk("midrst_inb", int'(inb1), 0);
    chk("midrst_x", int'(bx1), 0);
    repeat (3) @(posedge clk);
    vs_edge1('{12'd4, 12'd2, 3'd0});

    // FRAME_DIV=3 instance: every third counted frame moves; paused frames leave frame_cnt alone.
    for (int i = 0; i < 14; i++)
      vs_edge3('{12'(ex3[i]), 12'(ey3[i]), 3'd0}, pz3[i] != 0);

    repeat (10) @(posedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    chk("inbq_drained", inb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
